// File: rtl/port_pkg.sv
// Shared types and defaults for the switch port requester.
package port_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int STARVE_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

endpackage

// File: rtl/req_fifo.sv
// Flit FIFO for the port requester: payload plus last bit, no bypass.
module req_fifo
    import port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wlast,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              rlast,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign rdata = mem[rd_ptr][DATA_W-1:0];
    assign rlast = mem[rd_ptr][DATA_W];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {wlast, wdata};
    end

endmodule

// File: rtl/port_requester.sv
// Switch input port: flit FIFO, packet-lock FSM and arbiter request.
// Optional PORT_STARVE_CNT_EN adds a saturating starvation counter.
module port_requester
    import port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                req,
    input  logic                block,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    output logic                pkt_active
`ifdef PORT_STARVE_CNT_EN
    ,
    output logic [STARVE_W-1:0] starve_cnt
`endif
);

    state_t              state_q;
    state_t              state_d;
    logic                empty;
    logic                full;
    logic                grant;
    logic [DATA_W-1:0]   head_data;
    logic                head_last;

    req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .wdata (in_data),
        .wlast (in_last),
        .pop   (grant),
        .rdata (head_data),
        .rlast (head_last),
        .empty (empty),
        .full  (full)
    );

    assign in_ready = !full;

    // A non-empty FIFO always implies req, so grant needs only these two.
    assign grant = !empty && !block;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req        = !empty;
        pkt_active = 1'b0;
        out_valid  = grant;
        out_data   = '0;
        out_last   = 1'b0;
        if (grant) begin
            out_data = head_data;
            out_last = head_last;
        end
        unique case (state_q)
            IDLE: begin
                if (grant && !head_last) state_d = PKT;
            end
            PKT: begin
                req        = 1'b1;
                pkt_active = 1'b1;
                if (grant && head_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PORT_STARVE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant) begin
            starve_cnt <= '0;
        end else if (req && block && (starve_cnt != '1)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_port_requester.sv
// Bench for port_requester: directed scenarios plus random traffic vs a queue model.
module tb_port_requester;
    import port_pkg::*;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          req;
    logic          block;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          pkt_active;
`ifdef PORT_STARVE_CNT_EN
    logic [STARVE_W-1:0] starve_cnt;
`endif

    always #5 clk = ~clk;

    port_requester #(
        .DATA_W (DW),
        .DEPTH  (DP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .req        (req),
        .block      (block),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .pkt_active (pkt_active)
`ifdef PORT_STARVE_CNT_EN
        ,
        .starve_cnt (starve_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: packet queue, "inside a packet" flag, starvation count.
    logic [DW:0]   mq[$];
    bit            m_pkt;
    int            m_starve;
    logic [DW-1:0] seen[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d,
                        input bit l, input bit b);
        bit            g;
        bit            p;
        bit            r;
        bit            hl;
        logic [DW-1:0] hd;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        block    = b;
        #3;
        r  = m_pkt || (mq.size() > 0);
        g  = (mq.size() > 0) && !b;
        p  = v && (mq.size() < DP);
        hd = '0;
        hl = 1'b0;
        if (g) begin
            hd = mq[0][DW-1:0];
            hl = mq[0][DW];
        end
        check("in_ready",   in_ready,   mq.size() < DP);
        check("req",        req,        r);
        check("out_valid",  out_valid,  g);
        check("out_data",   out_data,   hd);
        check("out_last",   out_last,   hl);
        check("pkt_active", pkt_active, m_pkt);
`ifdef PORT_STARVE_CNT_EN
        check("starve_cnt", starve_cnt, m_starve);
`endif
        if (out_valid === 1'b1) seen.push_back(out_data);
        @(posedge clk);
        #1;
        if (g) begin
            void'(mq.pop_front());
            m_pkt = !hl;
        end
        if (p) mq.push_back({l, d});
        if (g) m_starve = 0;
        else if (r && b && m_starve < 65535) m_starve++;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        block    = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_req",   req,        0);
        check("rst_valid", out_valid,  0);
        check("rst_pkt",   pkt_active, 0);
        check("rst_data",  out_data,   0);
        check("rst_last",  out_last,   0);
        mq.delete();
        m_pkt    = 1'b0;
        m_starve = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ready", in_ready, 1);
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        block    = 1'b0;
        #2;
        apply_reset();

        // Three-flit packet streamed straight through.
        seen.delete();
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        check("seq_len", seen.size(), 3);
        if (seen.size() == 3) begin
            check("seq0", seen[0], 8'h11);
            check("seq1", seen[1], 8'h22);
            check("seq2", seen[2], 8'h33);
        end
        check("seq_idle", pkt_active, 0);

        // Fill while blocked, then drain in order.
        seen.delete();
        step(1, 8'hA1, 0, 1);
        step(1, 8'hA2, 0, 1);
        step(1, 8'hA3, 0, 1);
        step(1, 8'hA4, 1, 1);
        check("full_ready", in_ready, 0);
        step(1, 8'h55, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 0);
        check("drain_len", seen.size(), 4);
        if (seen.size() == 4) check("drain3", seen[3], 8'hA4);
        check("drain_ready", in_ready, 1);

        // Packet with an upstream stall: bubbles keep the lock.
        step(1, 8'hB1, 0, 0);
        step(1, 8'hB2, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0);
        check("stall_pkt", pkt_active, 1);
        check("stall_req", req, 1);
        step(1, 8'hB3, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        check("stall_end", pkt_active, 0);

        // Reset mid-packet with two flits queued.
        step(1, 8'h41, 0, 0);
        step(1, 8'h42, 0, 0);
        step(1, 8'h43, 1, 1);
        check("mid_pkt", pkt_active, 1);
        apply_reset();
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                step($urandom_range(0, 99) < 60, 8'($urandom),
                     $urandom_range(0, 99) < 35,
                     $urandom_range(0, 99) < 30);
            end
        end
        for (int i = 0; i < 12; i++) step(0, 8'h00, 1, 0);
        step(1, 8'h99, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

`ifdef PORT_STARVE_CNT_EN
        apply_reset();
        step(1, 8'h77, 1, 1);
        for (int i = 0; i < 70000; i++) step(0, 8'h00, 0, 1);
        check("starve_sat", starve_cnt, 16'hFFFF);
        step(0, 8'h00, 0, 0);
        check("starve_clr", starve_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
